// File: rtl/iob_eth_tx.sv
// MII transmit engine: preamble, SFD, buffered payload, zero pad, CRC-32 FCS, then inter-frame gap.
// Registered outputs, first nibble one cycle after an accepted send; send is ignored while busy.
module iob_eth_tx #(
    parameter int PREAMBLE_BYTES = 7,
    parameter int MIN_BYTES      = 60,
    parameter int IFG_BYTES      = 12
) (
    input  logic        TX_CLK,
    input  logic        rst,
    input  logic        send,
    input  logic [10:0] nbytes,
    output logic        ready,
    output logic [10:0] tx_addr,
    input  logic [7:0]  tx_data,
    output logic        TX_EN,
    output logic [3:0]  TX_DATA,
    output logic        frameSent
);
    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG} state_t;

    localparam logic [11:0] PRE_LAST = 12'(PREAMBLE_BYTES * 2 - 1);
    localparam logic [11:0] IFG_LAST = 12'(IFG_BYTES * 2 - 1);
    localparam logic [10:0] MIN_LEN  = 11'(MIN_BYTES);

    state_t      state, state_nxt;
    logic [11:0] cnt, cnt_nxt;
    logic [10:0] nb, nb_nxt;
    logic [10:0] pad_len, pad_nxt;
    logic [10:0] addr_nxt;
    logic [7:0]  byte_reg, byte_nxt;
    logic [31:0] crc, crc_nxt, crc_base;
    logic [31:0] fcs, fcs_nxt;
    logic        en_nxt, ready_nxt, sent_nxt;
    logic [3:0]  nib_nxt;
    logic        start_data, start_pad, start_fcs;
    logic [11:0] pad_diff;

    function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 4; i++) begin
            r = (r[0] ^ d[i]) ? ({1'b0, r[31:1]} ^ 32'hEDB8_8320) : {1'b0, r[31:1]};
        end
        return r;
    endfunction

    // Negative result (bit 11) means the payload already meets the minimum.
    assign pad_diff = {1'b0, MIN_LEN} - {1'b0, nbytes};

    always_ff @(posedge TX_CLK) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            nb        <= '0;
            pad_len   <= '0;
            byte_reg  <= '0;
            crc       <= '0;
            fcs       <= '0;
            ready     <= 1'b1;
            tx_addr   <= '0;
            TX_EN     <= 1'b0;
            TX_DATA   <= '0;
            frameSent <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            nb        <= nb_nxt;
            pad_len   <= pad_nxt;
            byte_reg  <= byte_nxt;
            crc       <= crc_nxt;
            fcs       <= fcs_nxt;
            ready     <= ready_nxt;
            tx_addr   <= addr_nxt;
            TX_EN     <= en_nxt;
            TX_DATA   <= nib_nxt;
            frameSent <= sent_nxt;
        end
    end

    // cnt counts nibbles already on the wire in the current state; cnt[0]=1 means phase H.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt + 12'd1;
        nb_nxt     = nb;
        pad_nxt    = pad_len;
        byte_nxt   = byte_reg;
        fcs_nxt    = fcs;
        addr_nxt   = tx_addr;
        en_nxt     = 1'b1;
        nib_nxt    = 4'h0;
        ready_nxt  = 1'b0;
        sent_nxt   = 1'b0;
        start_data = 1'b0;
        start_pad  = 1'b0;
        start_fcs  = 1'b0;
        crc_base   = (state == SFD) ? 32'hFFFF_FFFF : crc;

        unique case (state)
            IDLE: begin
                en_nxt    = 1'b0;
                ready_nxt = 1'b1;
                cnt_nxt   = '0;
                if (send) begin
                    state_nxt = PRE;
                    en_nxt    = 1'b1;
                    ready_nxt = 1'b0;
                    nib_nxt   = 4'h5;
                    nb_nxt    = nbytes;
                    pad_nxt   = pad_diff[11] ? 11'd0 : pad_diff[10:0];
                end
            end
            PRE: begin
                nib_nxt = 4'h5;
                if (cnt == PRE_LAST) begin
                    state_nxt = SFD;
                    cnt_nxt   = '0;
                end
            end
            SFD: begin
                if (!cnt[0])            nib_nxt    = 4'hD;
                else if (nb != 11'd0)   start_data = 1'b1;
                else if (pad_len != 0)  start_pad  = 1'b1;
                else                    start_fcs  = 1'b1;
            end
            DATA: begin
                if (!cnt[0])                         nib_nxt    = byte_reg[7:4];
                else if (cnt[11:1] != nb - 11'd1)    start_data = 1'b1;
                else if (pad_len != 11'd0)           start_pad  = 1'b1;
                else                                 start_fcs  = 1'b1;
            end
            PAD: begin
                if (cnt[0] && cnt[11:1] == pad_len - 11'd1) start_fcs = 1'b1;
            end
            FCS: begin
                nib_nxt = fcs[3:0];
                fcs_nxt = {4'h0, fcs[31:4]};
                if (cnt == 12'd7) begin
                    state_nxt = IFG;
                    cnt_nxt   = '0;
                    en_nxt    = 1'b0;
                    nib_nxt   = 4'h0;
                    addr_nxt  = '0;
                end
            end
            IFG: begin
                en_nxt = 1'b0;
                if (cnt == IFG_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    ready_nxt = 1'b1;
                    sent_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // tx_data holds the byte addressed two cycles earlier; fetch the next one now.
        if (start_data) begin
            state_nxt = DATA;
            byte_nxt  = tx_data;
            nib_nxt   = tx_data[3:0];
            addr_nxt  = tx_addr + 11'd1;
            if (state != DATA) cnt_nxt = '0;
        end
        if (start_pad) begin
            state_nxt = PAD;
            cnt_nxt   = '0;
        end
        if (start_fcs) begin
            state_nxt = FCS;
            cnt_nxt   = '0;
            nib_nxt   = ~crc_base[3:0];
            fcs_nxt   = {4'h0, ~crc_base[31:4]};
        end

        crc_nxt = (state_nxt == DATA || state_nxt == PAD) ? crc_nib(crc_base, nib_nxt) : crc_base;
    end
endmodule

// File: tb/tb_iob_eth_tx.sv
// Bench for iob_eth_tx: default instance plus a no-padding instance, nibble/address scoreboard.
module tb_iob_eth_tx;
    typedef struct packed {
        logic [3:0]  nib;
        logic [10:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        send0, send1;
    logic [10:0] nbytes0, nbytes1;
    logic        ready0, ready1, en0, en1, fs0, fs1;
    logic [10:0] addr0, addr1;
    logic [7:0]  rd0, rd1;
    logic [3:0]  nib0, nib1;
    logic [7:0]  mem0 [2048];
    logic [7:0]  mem1 [2048];

    iob_eth_tx dut (
        .TX_CLK(clk), .rst(rst), .send(send0), .nbytes(nbytes0), .ready(ready0),
        .tx_addr(addr0), .tx_data(rd0), .TX_EN(en0), .TX_DATA(nib0), .frameSent(fs0)
    );

    iob_eth_tx #(.MIN_BYTES(0)) dut_np (
        .TX_CLK(clk), .rst(rst), .send(send1), .nbytes(nbytes1), .ready(ready1),
        .tx_addr(addr1), .tx_data(rd1), .TX_EN(en1), .TX_DATA(nib1), .frameSent(fs1)
    );

    always @(posedge clk) begin
        rd0 <= mem0[addr0];
        rd1 <= mem1[addr1];
    end

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];
    int   l0[$];
    int   l1[$];

    int          run    [2] = '{0, 0};
    int          gap    [2] = '{0, 0};
    int          en_tot [2] = '{0, 0};
    int          sent_n [2] = '{0, 0};
    logic [31:0] crc_rx [2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [3:0]  lo     [2] = '{4'h0, 4'h0};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    task automatic push_exp(input int i, input logic [3:0] nib, input logic [10:0] a);
        exp_t e;
        e.nib  = nib;
        e.addr = a;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic push_frame(input int i, input int n);
        int          minb;
        int          tot;
        logic [31:0] c;
        logic [7:0]  b;
        logic [10:0] a;
        minb = (i == 0) ? 60 : 0;
        tot  = (n > minb) ? n : minb;
        c    = 32'hFFFF_FFFF;
        for (int k = 0; k < 15; k++) push_exp(i, 4'h5, 11'd0);
        push_exp(i, 4'hD, 11'd0);
        for (int k = 0; k < tot; k++) begin
            if (k < n) begin
                b = (i == 0) ? mem0[k] : mem1[k];
                a = 11'(k + 1);
            end else begin
                b = 8'h00;
                a = 11'(n);
            end
            push_exp(i, b[3:0], a);
            push_exp(i, b[7:4], a);
            c = crc_byte(c, b);
        end
        c = ~c;
        for (int k = 0; k < 8; k++) push_exp(i, c[4*k +: 4], 11'(n));
        if (i == 0) l0.push_back(2 * (8 + tot + 4));
        else        l1.push_back(2 * (8 + tot + 4));
    endtask

    task automatic mon(input int i, input logic en, input logic [3:0] nib, input logic [10:0] addr,
                       input logic rdy, input logic fs);
        exp_t e;
        int   exp_len;
        if (rst) begin
            run[i]    = 0;
            gap[i]    = 0;
            crc_rx[i] = 32'hFFFF_FFFF;
            return;
        end
        if (en) begin
            run[i]++;
            en_tot[i]++;
            gap[i] = 0;
            check("busy_ready", 32'(rdy), 32'd0);
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                check("extra_nibble", 32'(nib), 32'hFFFF_FFFF);
            end else begin
                if (i == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check("nibble", 32'(nib), 32'(e.nib));
                check("tx_addr", 32'(addr), 32'(e.addr));
            end
            if (run[i] % 2 == 1) lo[i] = nib;
            else if (run[i] > 16) crc_rx[i] = crc_byte(crc_rx[i], {nib, lo[i]});
        end else begin
            if (run[i] != 0) begin
                if (i == 0 && l0.size() != 0)      exp_len = l0.pop_front();
                else if (i == 1 && l1.size() != 0) exp_len = l1.pop_front();
                else                               exp_len = -1;
                check("en_length", run[i], exp_len);
                check("fcs_residue", crc_rx[i], 32'hDEBB_20E3);
                check("ifg_addr", 32'(addr), 32'd0);
                run[i]    = 0;
                crc_rx[i] = 32'hFFFF_FFFF;
            end
            gap[i]++;
        end
        if (fs) begin
            sent_n[i]++;
            check("ifg_gap", gap[i], 25);
            check("sent_ready", 32'(rdy), 32'd1);
        end
    endtask

    always @(negedge clk) begin
        mon(0, en0, nib0, addr0, ready0, fs0);
        mon(1, en1, nib1, addr1, ready1, fs1);
    end

    task automatic start(input int i, input int n);
        push_frame(i, n);
        if (i == 0) begin
            send0   = 1'b1;
            nbytes0 = 11'(n);
        end else begin
            send1   = 1'b1;
            nbytes1 = 11'(n);
        end
        @(posedge clk);
        #1;
        send0   = 1'b0;
        send1   = 1'b0;
        nbytes0 = 11'($urandom);
        nbytes1 = 11'($urandom);
    endtask

    task automatic wait_sent(input int i, input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (((i == 0) ? fs0 : fs1) !== 1'b1 && k < budget);
        check("sent_seen", 32'((i == 0) ? fs0 : fs1), 32'd1);
    endtask

    initial begin
        int k;
        send0 = 1'b0; send1 = 1'b0; nbytes0 = '0; nbytes1 = '0;
        for (int j = 0; j < 2048; j++) begin
            mem0[j] = 8'($urandom);
            mem1[j] = 8'($urandom);
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready0), 32'd1);
        check("rst_en", 32'(en0), 32'd0);
        check("rst_data", 32'(nib0), 32'd0);
        check("rst_addr", 32'(addr0), 32'd0);
        check("rst_sent", 32'(fs0), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        repeat (100) @(negedge clk);
        check("idle_sent", sent_n[0], 0);
        check("idle_en", en_tot[0], 0);

        for (int j = 0; j < 9; j++) mem1[j] = 8'h31 + 8'(j);
        start(1, 9);
        wait_sent(1, 300);
        @(negedge clk);

        start(0, 14);
        wait_sent(0, 400);

        start(0, 64);
        wait_sent(0, 400);

        start(0, 20);
        repeat (40) @(negedge clk);
        send0 = 1'b1; nbytes0 = 11'd5;
        @(negedge clk);
        send0 = 1'b0;
        k = 0;
        while (en0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("busy_frame_end", 32'(en0), 32'd0);
        repeat (5) @(negedge clk);
        send0 = 1'b1; nbytes0 = 11'd3;
        @(negedge clk);
        send0 = 1'b0;
        repeat (5) @(negedge clk);
        push_frame(0, 10);
        send0 = 1'b1; nbytes0 = 11'd10;
        wait_sent(0, 100);
        check("b2b_pre_en", 32'(en0), 32'd0);
        @(negedge clk);
        check("b2b_start_en", 32'(en0), 32'd1);
        check("b2b_start_nib", 32'(nib0), 32'd5);
        send0 = 1'b0; nbytes0 = 11'h7FF;
        wait_sent(0, 400);

        start(0, 30);
        k = 0;
        while (run[0] < 139 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("abort_in_fcs", 32'(run[0] >= 139), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_en", 32'(en0), 32'd0);
        check("abort_ready", 32'(ready0), 32'd1);
        check("abort_addr", 32'(addr0), 32'd0);
        check("abort_data", 32'(nib0), 32'd0);
        q0.delete();
        l0.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start(0, 40);
        wait_sent(0, 400);

        repeat (3) @(negedge clk);
        check("q0_left", q0.size(), 0);
        check("q1_left", q1.size(), 0);
        check("l0_left", l0.size(), 0);
        check("l1_left", l1.size(), 0);
        check("sent_total0", sent_n[0], 5);
        check("sent_total1", sent_n[1], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
